// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator control path.
//   arithmetic_t : operation codes sent to the ALU (index of the arithmetic button)
//   seq_state_t  : sequencer states
//   LED_*        : active-low status LED patterns
//   ERROR_VALUE  : value parked on the display when the ALU never answers
package calc_pkg;

  typedef enum logic [1:0] {
    PLUS           = 2'd0,
    SUBSTRACTION   = 2'd1,
    MULTIPLICATION = 2'd2,
    DEVISION       = 2'd3
  } arithmetic_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    SHOW  = 2'd3
  } seq_state_t;

  localparam logic [2:0] LED_IDLE   = 3'b110;
  localparam logic [2:0] LED_FIRST  = 3'b101;
  localparam logic [2:0] LED_SECOND = 3'b011;

  localparam int ERROR_VALUE = -1000;

endpackage

// File: rtl/calc_debouncer.sv
// One active-low button: 2-flop synchroniser, stable-sample counter,
// debounced level and a single-cycle press pulse.
//   clk, rst  : clock, asynchronous active-high reset
//   btn_i     : raw pin (active-low)
//   level_o   : debounced level (1 = released)
//   press_o   : one-cycle pulse on a debounced 1->0 transition
module calc_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the synchronised sample disagrees with the
  // current level; any agreeing sample restarts the run from zero.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync_q[1];
      else                                   cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = prev_q & ~level_q;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control sequencer: conditions board inputs, latches operands on
// the enter keys, issues one ALU operation per arithmetic press over a
// valid/ready handshake, waits for the result (with timeout) and holds it on
// the display while the issuing button stays pressed.
//   in_number/arif/key        : raw active-low board inputs
//   op_valid/op_ready/op_code : ALU request handshake, operand_a/operand_b
//   alu_done/alu_result/alu_err : ALU completion strobe and result
//   disp_value/disp_point/disp_err : display driver data
//   led                       : active-low status LEDs
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int IN_WIDTH                 = 4,
  parameter int NUMBER_OF_ARITHM_BUTTONS = 4,
  parameter int NUMBER_OF_ENTER_BUTTONS  = 2,
  parameter int LED_WIDTH                = 3,
  parameter int RES_WIDTH                = 12,
  parameter int DEBOUNCE_CYCLES          = 16,
  parameter int TIMEOUT_CYCLES           = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [IN_WIDTH-1:0]                 in_number,
  input  logic [NUMBER_OF_ARITHM_BUTTONS-1:0] arif,
  input  logic [NUMBER_OF_ENTER_BUTTONS-1:0]  key,
  output logic                                op_valid,
  input  logic                                op_ready,
  output logic [1:0]                          op_code,
  output logic [IN_WIDTH-1:0]                 operand_a,
  output logic [IN_WIDTH-1:0]                 operand_b,
  input  logic                                alu_done,
  input  logic [RES_WIDTH-1:0]                alu_result,
  input  logic                                alu_err,
  output logic [RES_WIDTH-1:0]                disp_value,
  output logic                                disp_point,
  output logic                                disp_err,
  output logic [LED_WIDTH-1:0]                led
);

  localparam int NA = NUMBER_OF_ARITHM_BUTTONS;
  localparam int NK = NUMBER_OF_ENTER_BUTTONS;
  localparam int NB = NA + NK;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------- input conditioning ----------------
  logic [NB-1:0] btn, lvl, prs;
  logic [NA-1:0] arif_lvl, arif_press;
  logic [NK-1:0] key_press;
  logic          unused_key_lvl;

  assign btn = {key, arif};

  calc_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn [NB-1:0] (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn),
    .level_o (lvl),
    .press_o (prs)
  );

  assign arif_lvl       = lvl[NA-1:0];
  assign arif_press     = prs[NA-1:0];
  assign key_press      = prs[NB-1:NA];
  assign unused_key_lvl = ^lvl[NB-1:NA];

  // Operand switches are only synchronised; they are sampled on key presses.
  logic [IN_WIDTH-1:0] num_s1_q, num_s2_q, num_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_s1_q <= '1;
      num_s2_q <= '1;
    end else begin
      num_s1_q <= in_number;
      num_s2_q <= num_s1_q;
    end
  end

  assign num_val = ~num_s2_q;

  // Count debounced-low arithmetic buttons; an operation is only accepted
  // when exactly one is down, and that one names the operation.
  int         low_cnt;
  logic [1:0] low_idx;

  always_comb begin
    low_cnt = 0;
    low_idx = '0;
    for (int i = 0; i < NA; i++) begin
      if (!arif_lvl[i]) begin
        low_cnt = low_cnt + 1;
        low_idx = 2'(i);
      end
    end
  end

  // ---------------- sequencer ----------------
  seq_state_t           state_q, state_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [IN_WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d;
  logic                 op_valid_q, op_valid_d;
  arithmetic_t          op_code_q, op_code_d;
  logic [RES_WIDTH-1:0] disp_value_q, disp_value_d;
  logic                 disp_point_q, disp_point_d;
  logic                 disp_err_q, disp_err_d;
  logic [TW-1:0]        tmo_q, tmo_d;

  always_comb begin
    state_d      = state_q;
    led_d        = led_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    op_valid_d   = op_valid_q;
    op_code_d    = op_code_q;
    disp_value_d = disp_value_q;
    disp_point_d = disp_point_q;
    disp_err_d   = disp_err_q;
    tmo_d        = tmo_q;

    unique case (state_q)
      IDLE: begin
        disp_value_d = RES_WIDTH'(num_val);
        disp_point_d = 1'b0;
        disp_err_d   = 1'b0;
        // Both enter keys in the same cycle is ambiguous: ignore both.
        if (key_press[0] && !key_press[1]) begin
          opa_d = num_val;
          led_d = LED_FIRST;
        end else if (key_press[1] && !key_press[0]) begin
          opb_d = num_val;
          led_d = LED_SECOND;
        end
        if (|arif_press && low_cnt == 1) begin
          op_code_d  = arithmetic_t'(low_idx);
          op_valid_d = 1'b1;
          led_d      = LED_IDLE;
          state_d    = ISSUE;
        end
      end

      ISSUE: begin
        if (op_ready) begin
          op_valid_d = 1'b0;
          tmo_d      = '0;
          state_d    = WAIT;
        end
      end

      WAIT: begin
        // A result arriving on the expiry cycle takes precedence.
        if (alu_done) begin
          disp_value_d = alu_result;
          disp_err_d   = alu_err;
          disp_point_d = (op_code_q == DEVISION) && !alu_err;
          state_d      = SHOW;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          disp_value_d = RES_WIDTH'(ERROR_VALUE);
          disp_err_d   = 1'b1;
          disp_point_d = 1'b0;
          state_d      = SHOW;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      SHOW: begin
        if (arif_lvl[op_code_q]) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      led_q        <= LED_IDLE;
      opa_q        <= '0;
      opb_q        <= '0;
      op_valid_q   <= 1'b0;
      op_code_q    <= PLUS;
      disp_value_q <= '0;
      disp_point_q <= 1'b0;
      disp_err_q   <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      led_q        <= led_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      op_valid_q   <= op_valid_d;
      op_code_q    <= op_code_d;
      disp_value_q <= disp_value_d;
      disp_point_q <= disp_point_d;
      disp_err_q   <= disp_err_d;
      tmo_q        <= tmo_d;
    end
  end

  assign op_valid   = op_valid_q;
  assign op_code    = op_code_q;
  assign operand_a  = opa_q;
  assign operand_b  = opb_q;
  assign disp_value = disp_value_q;
  assign disp_point = disp_point_q;
  assign disp_err   = disp_err_q;
  assign led        = led_q;

endmodule

// File: tb/tb_calc_sequencer.sv
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int IW = 4, NA = 4, NK = 2, LW = 3, RW = 12, D = 16, T = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] in_number;
  logic [NA-1:0] arif;
  logic [NK-1:0] key;
  logic          op_valid;
  logic          op_ready = 1'b0;
  logic [1:0]    op_code;
  logic [IW-1:0] operand_a, operand_b;
  logic          alu_done = 1'b0;
  logic [RW-1:0] alu_result = '0;
  logic          alu_err = 1'b0;
  logic [RW-1:0] disp_value;
  logic          disp_point, disp_err;
  logic [LW-1:0] led;

  always #5 clk = ~clk;

  calc_sequencer dut (
    .clk(clk), .rst(rst), .in_number(in_number), .arif(arif), .key(key),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .operand_a(operand_a), .operand_b(operand_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
    .disp_value(disp_value), .disp_point(disp_point), .disp_err(disp_err),
    .led(led)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- cycle counter and ALU model ----------------
  int cyc = 0;
  always @(posedge clk) cyc++;

  int ready_dly = 0, done_dly = 1;
  int vld_n = 0, hs_cnt = 0, hs_cyc = 0, vld_cycles = 0;
  int hs_code = 0, hs_a = 0, hs_b = 0;
  bit pend = 0;

  // Acts at negedges: raising op_ready here means the handshake completes at
  // the next posedge, since the DUT holds op_valid until then.
  always @(negedge clk) begin
    int r;
    op_ready = 1'b0;
    alu_done = 1'b0;
    alu_err  = 1'b0;
    if (rst) begin
      vld_n = 0;
      pend  = 0;
    end else begin
      if (pend && done_dly > 0 && cyc == hs_cyc + done_dly - 1) begin
        pend = 0;
        case (hs_code)
          0: r = hs_a + hs_b;
          1: r = hs_a - hs_b;
          2: r = hs_a * hs_b;
          default: begin
            if (hs_b == 0) begin r = ERROR_VALUE; alu_err = 1'b1; end
            else r = (100 * hs_a) / hs_b;
          end
        endcase
        alu_result = RW'(r);
        alu_done   = 1'b1;
      end
      if (op_valid) begin
        if (vld_n == ready_dly) begin
          op_ready   = 1'b1;
          hs_cnt++;
          hs_cyc     = cyc + 1;
          vld_cycles = vld_n + 1;
          hs_code    = int'(op_code);
          hs_a       = int'(operand_a);
          hs_b       = int'(operand_b);
          vld_n      = 0;
          pend       = 1;
        end else vld_n++;
      end else vld_n = 0;
    end
  end

  // ---------------- reference model state ----------------
  int ma = 0, mb = 0, sw = 0, mled = 6;

  // Display outcome the calculator should show for an operation.
  function automatic void ref_op(input int op, input int a, input int b,
                                 output int v, output int pt, output int er);
    pt = 0; er = 0;
    case (op)
      0: v = a + b;
      1: v = a - b;
      2: v = a * b;
      default: begin
        if (b == 0) begin v = ERROR_VALUE; er = 1; end
        else begin v = (a * 100) / b; pt = 1; end
      end
    endcase
  endfunction

  task automatic set_sw(input int v);
    sw = v;
    in_number = ~IW'(v);
  endtask

  task automatic press_key(input int k, input int v);
    set_sw(v);
    key[k] = 1'b0;
    repeat (3 * D) @(negedge clk);
    key[k] = 1'b1;
    repeat (3 * D) @(negedge clk);
    if (k == 0) begin ma = v; mled = 5; end
    else        begin mb = v; mled = 3; end
    chk(k == 0 ? "operand_a" : "operand_b", k == 0 ? int'(operand_a) : int'(operand_b), v);
    chk("led_key", int'(led), mled);
  endtask

  // dn == 0 means the ALU never answers; dn > T lands after the timeout.
  task automatic run_op(input int idx, input int rdy, input int dn);
    int h0, v, pt, er;
    bit tmo;
    h0 = hs_cnt;
    ready_dly = rdy;
    done_dly  = dn;
    tmo = (dn == 0 || dn > T);
    ref_op(idx, ma, mb, v, pt, er);
    if (tmo) begin er = 1; pt = 0; end
    arif[idx] = 1'b0;
    repeat (D + T + rdy + 14) @(negedge clk);
    chk("hs_count", hs_cnt - h0, 1);
    chk("op_code", hs_code, idx);
    chk("hs_operand_a", hs_a, ma);
    chk("hs_operand_b", hs_b, mb);
    chk("vld_cycles", vld_cycles, rdy + 1);
    chk("op_valid_low", int'(op_valid), 0);
    if (!tmo && er == 0) chk("disp_value", int'($signed(disp_value)), v);
    chk("disp_point", int'(disp_point), pt);
    chk("disp_err", int'(disp_err), er);
    chk("led_show", int'(led), 6);
    mled = 6;
    arif[idx] = 1'b1;
    repeat (D + 6) @(negedge clk);
    chk("hs_once", hs_cnt - h0, 1);
    chk("disp_live", int'($signed(disp_value)), sw);
    chk("disp_err_live", int'(disp_err), 0);
    chk("disp_point_live", int'(disp_point), 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_led", int'(led), 6);
    chk("rst_operand_a", int'(operand_a), 0);
    chk("rst_operand_b", int'(operand_b), 0);
    chk("rst_op_valid", int'(op_valid), 0);
    chk("rst_op_code", int'(op_code), 0);
    chk("rst_disp_value", int'(disp_value), 0);
    chk("rst_disp_point", int'(disp_point), 0);
    chk("rst_disp_err", int'(disp_err), 0);
  endtask

  initial begin
    int n, h0, l0;
    rst = 1'b1;
    in_number = '1;
    arif = '1;
    key = '1;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Test 1: operand entry, with press-to-update latency on key[0]
    set_sw(7);
    repeat (4) @(negedge clk);
    chk("disp_track", int'(disp_value), 7);
    key[0] = 1'b0;
    n = 0;
    while (led == 3'b110 && n < 3 * D) begin @(negedge clk); n++; end
    chk("press_latency", n, D + 3);
    repeat (3 * D - n) @(negedge clk);
    key[0] = 1'b1;
    repeat (3 * D) @(negedge clk);
    ma = 7; mled = 5;
    chk("operand_a", int'(operand_a), 7);
    chk("led_first", int'(led), 5);
    press_key(1, 3);

    // Tests 2/3: MUL, DIV, DIV by zero
    run_op(2, 2, 5);
    run_op(3, 1, 3);
    press_key(1, 0);
    run_op(3, 0, 4);

    // Test 4: glitch, two buttons low, both keys together
    press_key(1, 4);
    press_key(0, 5);
    h0 = hs_cnt; l0 = int'(led);
    arif[0] = 1'b0;
    repeat (D - 2) @(negedge clk);
    arif[0] = 1'b1;
    repeat (3 * D) @(negedge clk);
    chk("glitch_no_op", hs_cnt - h0, 0);
    chk("glitch_led", int'(led), l0);
    arif = 4'b1010;
    repeat (3 * D) @(negedge clk);
    chk("two_low_valid", int'(op_valid), 0);
    arif = '1;
    repeat (3 * D) @(negedge clk);
    chk("two_low_no_op", hs_cnt - h0, 0);
    chk("two_low_led", int'(led), l0);
    set_sw(9);
    key = 2'b00;
    repeat (3 * D) @(negedge clk);
    key = '1;
    repeat (3 * D) @(negedge clk);
    chk("both_keys_a", int'(operand_a), ma);
    chk("both_keys_b", int'(operand_b), mb);
    chk("both_keys_led", int'(led), l0);

    // Test 5: slow ready then timeout, with exact timeout length
    ready_dly = 10; done_dly = 0;
    h0 = hs_cnt;
    arif[1] = 1'b0;
    n = 0;
    while (hs_cnt == h0 && n < 200) begin @(negedge clk); n++; end
    chk("tmo_hs_seen", hs_cnt - h0, 1);
    chk("tmo_vld_cycles", vld_cycles, 11);
    n = 0;
    while (!disp_err && n < 200) begin @(negedge clk); n++; end
    chk("tmo_length", cyc - hs_cyc, T);
    chk("tmo_err", int'(disp_err), 1);
    chk("tmo_led", int'(led), 6);
    repeat (20) @(negedge clk);
    chk("tmo_hold_err", int'(disp_err), 1);
    arif[1] = 1'b1;
    repeat (D + 6) @(negedge clk);
    chk("tmo_exit_err", int'(disp_err), 0);
    chk("tmo_exit_live", int'(disp_value), sw);

    // Result on the expiry cycle wins; one cycle later it is a timeout
    run_op(0, 1, T);
    run_op(1, 0, T + 1);

    // Randomised operations
    for (int it = 0; it < 6; it++) begin
      press_key(0, int'($urandom_range(0, 15)));
      press_key(1, int'($urandom_range(0, 15)));
      run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), int'($urandom_range(1, 8)));
    end

    // Reset during WAIT
    ready_dly = 0; done_dly = 0;
    h0 = hs_cnt;
    arif[3] = 1'b0;
    n = 0;
    while (hs_cnt == h0 && n < 200) begin @(negedge clk); n++; end
    chk("rst_wait_hs", hs_cnt - h0, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    arif = '1;
    #1;
    chk_reset_vals();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ma = 0; mb = 0;
    repeat (4) @(negedge clk);

    // op_valid drops without a clock edge when reset hits in ISSUE
    ready_dly = 100000;
    arif[0] = 1'b0;
    n = 0;
    while (!op_valid && n < 200) begin @(negedge clk); n++; end
    chk("issue_valid", int'(op_valid), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_op_valid", int'(op_valid), 0);
    chk("async_led", int'(led), 6);
    arif = '1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
